// File: rtl/alu_seq_pkg.sv
// Shared constants for the bit-serial ALU: opcodes, compare sub-functions,
// slice operation selects and the controller state encoding.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_CMP  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;

    localparam logic [2:0] FN_SLT  = 3'b000;
    localparam logic [2:0] FN_SLE  = 3'b001;
    localparam logic [2:0] FN_EQ   = 3'b010;
    localparam logic [2:0] FN_NE   = 3'b011;
    localparam logic [2:0] FN_SLTU = 3'b110;
    localparam logic [2:0] FN_SLEU = 3'b111;

    localparam logic [1:0] SL_AND = 2'b00;
    localparam logic [1:0] SL_OR  = 2'b01;
    localparam logic [1:0] SL_ADD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH,
        S_DONE
    } state_t;

    function automatic logic func_legal(input logic [2:0] f);
        case (f)
            FN_SLT, FN_SLE, FN_EQ, FN_NE, FN_SLTU, FN_SLEU: func_legal = 1'b1;
            default:                                        func_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_slice.sv
// Combinational 1-bit ALU slice: optional input inversion, then AND / OR / full-add.
module alu_seq_slice
    import alu_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       a_inv,
    input  logic       b_inv,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       res,
    output logic       cout
);

    logic w_a;
    logic w_b;

    assign w_a  = a ^ a_inv;
    assign w_b  = b ^ b_inv;
    assign cout = (w_a & w_b) | (cin & (w_a ^ w_b));

    always_comb begin
        res = 1'b0;
        case (op)
            SL_AND:  res = w_a & w_b;
            SL_OR:   res = w_a | w_b;
            SL_ADD:  res = w_a ^ w_b ^ cin;
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Bit-serial ALU controller: one shared slice processes operands LSB first.
// Define ALU_SEQ_OVF_EN to enable signed-overflow detection.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       operation_i,
    input  logic [2:0]       func_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             illegal_o
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic             r_a_inv;
    logic             r_b_inv;
    logic [1:0]       r_slop;
    logic             r_arith;
    logic             r_cmp;
    logic             r_illegal;
    logic [2:0]       r_func;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_cout;
    logic             r_ovf;
    logic             r_illegal_o;
`ifdef ALU_SEQ_OVF_EN
    logic             r_cmsb;
`endif

    logic [1:0]       w_dec_slop;
    logic             w_dec_a_inv;
    logic             w_dec_b_inv;
    logic             w_dec_cin;
    logic             w_dec_arith;
    logic             w_dec_cmp;
    logic             w_dec_illegal;
    logic             w_slice_res;
    logic             w_slice_cout;
    logic             w_ovf;
    logic             w_eq;
    logic             w_slt;
    logic             w_sltu;
    logic             w_cmp_bit;
    logic [WIDTH-1:0] w_final;

    always_comb begin
        w_dec_slop    = SL_AND;
        w_dec_a_inv   = 1'b0;
        w_dec_b_inv   = 1'b0;
        w_dec_cin     = 1'b0;
        w_dec_arith   = 1'b0;
        w_dec_cmp     = 1'b0;
        w_dec_illegal = 1'b0;
        case (operation_i)
            OP_AND: w_dec_slop = SL_AND;
            OP_OR:  w_dec_slop = SL_OR;
            OP_ADD: begin
                w_dec_slop  = SL_ADD;
                w_dec_arith = 1'b1;
            end
            OP_SUB: begin
                w_dec_slop  = SL_ADD;
                w_dec_b_inv = 1'b1;
                w_dec_cin   = 1'b1;
                w_dec_arith = 1'b1;
            end
            OP_CMP: begin
                w_dec_slop    = SL_ADD;
                w_dec_b_inv   = 1'b1;
                w_dec_cin     = 1'b1;
                w_dec_arith   = 1'b1;
                w_dec_cmp     = 1'b1;
                w_dec_illegal = !func_legal(func_i);
            end
            // De Morgan: NOR / NAND reuse the AND / OR slice with both inputs inverted
            OP_NOR: begin
                w_dec_slop  = SL_AND;
                w_dec_a_inv = 1'b1;
                w_dec_b_inv = 1'b1;
            end
            OP_NAND: begin
                w_dec_slop  = SL_OR;
                w_dec_a_inv = 1'b1;
                w_dec_b_inv = 1'b1;
            end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    alu_seq_slice u_slice (
        .a     (r_a[0]),
        .b     (r_b[0]),
        .a_inv (r_a_inv),
        .b_inv (r_b_inv),
        .cin   (r_carry),
        .op    (r_slop),
        .res   (w_slice_res),
        .cout  (w_slice_cout)
    );

`ifdef ALU_SEQ_OVF_EN
    assign w_ovf = r_cmsb ^ r_carry;
`else
    assign w_ovf = 1'b0;
`endif

    // In FINISH r_res holds the full difference and r_carry the MSB carry-out
    assign w_eq   = (r_res == '0);
    assign w_slt  = r_res[WIDTH-1] ^ w_ovf;
    assign w_sltu = !r_carry;

    always_comb begin
        w_cmp_bit = 1'b0;
        case (r_func)
            FN_SLT:  w_cmp_bit = w_slt;
            FN_SLTU: w_cmp_bit = w_sltu;
            FN_SLE:  w_cmp_bit = w_slt | w_eq;
            FN_SLEU: w_cmp_bit = w_sltu | w_eq;
            FN_EQ:   w_cmp_bit = w_eq;
            FN_NE:   w_cmp_bit = !w_eq;
            default: w_cmp_bit = 1'b0;
        endcase
    end

    assign w_final = r_illegal ? '0 :
                     r_cmp     ? {{(WIDTH-1){1'b0}}, w_cmp_bit} : r_res;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_illegal_o <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            r_cmsb      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_a       <= src1_i;
                        r_b       <= src2_i;
                        r_func    <= func_i;
                        r_slop    <= w_dec_slop;
                        r_a_inv   <= w_dec_a_inv;
                        r_b_inv   <= w_dec_b_inv;
                        r_arith   <= w_dec_arith;
                        r_cmp     <= w_dec_cmp;
                        r_illegal <= w_dec_illegal;
                        r_carry   <= w_dec_cin;
                        r_idx     <= '0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_res   <= {w_slice_res, r_res[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_slice_cout;
                    if (r_idx == LAST_IDX) begin
`ifdef ALU_SEQ_OVF_EN
                        r_cmsb  <= r_carry;
`endif
                        r_idx   <= '0;
                        r_state <= S_FINISH;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_result    <= w_final;
                    r_zero      <= (w_final == '0);
                    r_cout      <= r_arith & !r_illegal & r_carry;
                    r_ovf       <= r_arith & !r_illegal & w_ovf;
                    r_illegal_o <= r_illegal;
                    r_state     <= S_DONE;
                end
                // Outputs settle on DONE entry; valid follows one cycle later
                S_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = r_out_valid;
    assign result_o    = r_result;
    assign zero_o      = r_zero;
    assign cout_o      = r_cout;
    assign overflow_o  = r_ovf;
    assign illegal_o   = r_illegal_o;

endmodule
